// File: rtl/program_counter_if.sv
// Fetch-side bus of the program-counter stage: jump/stall/memory-ready inputs and
// the fetch request, fetch result and flush outputs.
interface program_counter_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  jump_valid;
  logic [ADDR_WIDTH-1:0] jump_address;
  logic                  stall;
  logic                  imem_ready;
  logic [ADDR_WIDTH-1:0] current_address;
  logic                  imem_req;
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  flush;

  modport master (
    input  jump_valid,
    input  jump_address,
    input  stall,
    input  imem_ready,
    output current_address,
    output imem_req,
    output fetch_valid,
    output fetch_addr,
    output flush
  );

  modport slave (
    output jump_valid,
    output jump_address,
    output stall,
    output imem_ready,
    input  current_address,
    input  imem_req,
    input  fetch_valid,
    input  fetch_addr,
    input  flush
  );
endinterface

// File: rtl/program_counter.sv
// Program-counter stage: owns the halfword-aligned fetch address and sequences
// sequential fetch, stalls, jump redirects and the wrong-path flush pulse.
module program_counter #(
  parameter int unsigned          ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input logic               clock,
  input logic               reset_n,
  program_counter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    REDIRECT
  } state_e;

  // Bit 0 is masked so a misconfigured RESET_ADDR still yields an aligned PC.
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = {RESET_ADDR[ADDR_WIDTH-1:1], 1'b0};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  fetch_valid_q, fetch_valid_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      fetch_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_addr_q  <= fetch_addr_d;
    end
  end

  // Jump outranks stall, which outranks a memory completion, which outranks increment.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = 1'b0;
    fetch_addr_d  = fetch_addr_q;

    if (bus.jump_valid) begin
      pc_d    = {bus.jump_address[ADDR_WIDTH-1:1], 1'b0};
      state_d = REDIRECT;
    end else begin
      unique case (state_q)
        IDLE, HOLD, REDIRECT: begin
          state_d = bus.stall ? HOLD : FETCH;
        end
        FETCH: begin
          if (bus.stall) begin
            state_d = HOLD;
          end else if (bus.imem_ready) begin
            fetch_valid_d = 1'b1;
            fetch_addr_d  = pc_q;
            pc_d          = pc_q + ADDR_WIDTH'(2);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.current_address = pc_q;
  assign bus.imem_req        = (state_q == FETCH);
  assign bus.flush           = (state_q == REDIRECT);
  assign bus.fetch_valid     = fetch_valid_q;
  assign bus.fetch_addr      = fetch_addr_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: expected fetch addresses are queued as
// completions are driven and matched against fetch_valid/fetch_addr.
module tb_program_counter;

  logic clock;
  logic reset_n;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] exp_q[$];

  program_counter_if #(.ADDR_WIDTH(16)) pif ();

  program_counter #(
    .ADDR_WIDTH(16),
    .RESET_ADDR(16'h0000)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (pif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic jv, input logic [15:0] ja, input logic st, input logic rdy);
    pif.jump_valid   = jv;
    pif.jump_address = ja;
    pif.stall        = st;
    pif.imem_ready   = rdy;
  endtask

  // Advance one edge, then score the fetch result that edge produced.
  task automatic tick();
    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      check_eq("fetch_valid", 32'(pif.fetch_valid), 32'd1);
      check_eq("fetch_addr", 32'(pif.fetch_addr), 32'(exp_q.pop_front()));
    end else begin
      check_eq("no_fetch_valid", 32'(pif.fetch_valid), 32'd0);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [15:0] pc, input logic req, input logic fl);
    check_eq({tag, "_pc"}, 32'(pif.current_address), 32'(pc));
    check_eq({tag, "_req"}, 32'(pif.imem_req), 32'(req));
    check_eq({tag, "_flush"}, 32'(pif.flush), 32'(fl));
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    check_ctl("rst", 16'h0000, 1'b0, 1'b0);
    check_eq("rst_fetch_addr", 32'(pif.fetch_addr), 32'h0);

    // Release and sequential fetch
    reset_n = 1'b1;
    tick();
    check_ctl("rel", 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(2 * i));
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("seq_end", 16'h0008, 1'b1, 1'b0);

    // Jump to C000, then a jump coincident with a completion
    drive(1'b1, 16'hC000, 1'b0, 1'b0);
    tick();
    check_ctl("j1", 16'hC000, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("j1_fetch", 16'hC000, 1'b1, 1'b0);
    drive(1'b1, 16'hC004, 1'b0, 1'b1);
    tick();
    check_ctl("j2", 16'hC004, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("j2_fetch", 16'hC004, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    exp_q.push_back(16'hC004);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("j2_next", 16'hC006, 1'b1, 1'b0);

    // Wrap-around at the top of the address space
    drive(1'b1, 16'hFFFC, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("wrap_start", 16'hFFFC, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    exp_q.push_back(16'hFFFC);
    tick();
    exp_q.push_back(16'hFFFE);
    tick();
    exp_q.push_back(16'h0000);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check_ctl("wrap_end", 16'h0002, 1'b1, 1'b0);

    // Stall for three edges at 0010 with ready pulsing
    drive(1'b1, 16'h0010, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("st_start", 16'h0010, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    check_ctl("st1", 16'h0010, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    check_ctl("st2", 16'h0010, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    check_ctl("st3", 16'h0010, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("st_rel", 16'h0010, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    exp_q.push_back(16'h0010);
    tick();
    exp_q.push_back(16'h0012);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // Jump to an odd target while stalled
    drive(1'b1, 16'h1235, 1'b1, 1'b1);
    tick();
    check_ctl("jst", 16'h1234, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    check_ctl("jst_hold1", 16'h1234, 1'b0, 1'b0);
    tick();
    check_ctl("jst_hold2", 16'h1234, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("jst_rel", 16'h1234, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    exp_q.push_back(16'h1234);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // Back-to-back jumps extend REDIRECT
    drive(1'b1, 16'h2000, 1'b0, 1'b0);
    tick();
    check_ctl("bb1", 16'h2000, 1'b0, 1'b1);
    drive(1'b1, 16'h3001, 1'b0, 1'b0);
    tick();
    check_ctl("bb2", 16'h3000, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("bb_fetch", 16'h3000, 1'b1, 1'b0);

    // Reset mid-fetch with a completion in the reset cycle
    reset_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    check_ctl("mrst", 16'h0000, 1'b0, 1'b0);
    check_eq("mrst_fetch_addr", 32'(pif.fetch_addr), 32'h0);
    reset_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_ctl("mrst_rel", 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    exp_q.push_back(16'h0000);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Program-counter stage that owns the 16-bit fetch address and drives the instruction-memory request. It supplies `current_address` to the jump-offset calculator and consumes the jump target that calculator produces. It also sequences sequential fetch (+2 per halfword instruction), stalls, jump redirects and the flush pulse that squashes the wrong-path fetch.

## Interface
- `ADDR_WIDTH`, 16: width of all address buses.
- `RESET_ADDR`, 16'h0000: value loaded into the PC on reset; bit 0 must be 0.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `jump_valid` input 1: jump target on `jump_address` is to be taken this cycle.
- `jump_address` input ADDR_WIDTH: target from the jump-offset stage.
- `stall` input 1: downstream cannot accept instructions; hold the PC.
- `imem_ready` input 1: instruction memory completes the outstanding request this cycle.
- `current_address` output ADDR_WIDTH: present PC value; also the fetch address presented to instruction memory.
- `imem_req` output 1: fetch request for `current_address`.
- `fetch_valid` output 1: one-cycle pulse; the word returned last cycle is valid for decode.
- `fetch_addr` output ADDR_WIDTH: address of the word flagged by `fetch_valid`.
- `flush` output 1: one-cycle pulse after a taken jump; downstream discards in-flight instructions.

## Operation
- States: IDLE, FETCH, HOLD, REDIRECT. State is held in registers. All outputs come from registers or from state only, with no combinational path from inputs to outputs.
- Reset (`reset_n`=0 at an edge):
  - `current_address`=RESET_ADDR, state=IDLE.
  - `imem_req`=0, `fetch_valid`=0, `fetch_addr`=0, `flush`=0.
  - Reset overrides every other input, including mid-fetch. An outstanding memory completion in the reset cycle is dropped.
- IDLE: `imem_req`=0. Goes to FETCH next cycle, or to HOLD if `stall`=1.
- FETCH: `imem_req`=1.
  - On `imem_ready`=1 with no jump and no stall: `fetch_valid`=1 and `fetch_addr`=old PC next cycle, PC <= PC+2. Stays in FETCH.
  - On `imem_ready`=0: PC holds and the request stays asserted.
- HOLD: entered from FETCH or IDLE when `stall`=1.
  - `imem_req`=0 and the PC holds.
  - A completion arriving in the same cycle `stall` rises is discarded: no `fetch_valid` and no increment, so the word is refetched.
  - Returns to FETCH the cycle after `stall`=0.
- REDIRECT: one cycle with `imem_req`=0 and `flush`=1. Then goes to FETCH, or to HOLD if `stall`=1.
- Jump priority (from any non-reset state): jump beats stall, beats `imem_ready`, beats increment.
  - PC <= {jump_address[15:1],1'b0}; bit 0 is forced to 0.
  - Next state is REDIRECT.
  - `fetch_valid` is suppressed for any completion in the same cycle.
- Arithmetic: PC+2 is modulo 2^ADDR_WIDTH, so 16'hFFFE wraps to 16'h0000 with no flag.
- Back-to-back jumps: a `jump_valid` during REDIRECT reloads the PC and extends REDIRECT by one cycle, giving another `flush` pulse.

## Timing
- Reset release: `imem_req` first goes high 1 cycle after the first edge with `reset_n`=1 (IDLE → FETCH).
- Fetch throughput: with `imem_ready` tied to 1 and `stall`=0, there is one `fetch_valid` per cycle with addresses increasing by 2.
- Fetch latency: `fetch_valid`/`fetch_addr` appear 1 cycle after the `imem_ready` edge.
- Jump at edge N:
  - `current_address`=target and `flush`=1 during cycle N+1, with `imem_req`=0.
  - `imem_req`=1 for the target during cycle N+2.
  - The first `fetch_valid` for the target comes no earlier than N+3.
- Stall: takes effect on the edge it is sampled; `imem_req` drops the following cycle.

## Test plan
- Reset with RESET_ADDR=16'h0000, then `imem_ready`=1 for 4 cycles -> `fetch_addr` 0000, 0002, 0004, 0006 on consecutive `fetch_valid` pulses; all outputs 0 during reset.
- PC=16'hC000, `jump_valid`=1, `jump_address`=16'hC004 together with `imem_ready`=1 -> no `fetch_valid`, `flush`=1 for exactly 1 cycle, next fetch at C004.
- PC=16'hFFFC, continuous ready -> fetch addresses FFFC, FFFE, 0000.
- `stall`=1 for 3 cycles while at 16'h0010 with ready pulsing -> `imem_req`=0 and PC stays 0010; refetch of 0010 after release, with no address skipped.
- `jump_address`=16'h1235 during `stall`=1 -> PC=1234, `flush` pulse, remains in HOLD until `stall`=0, then fetches 1234.
- `reset_n`=0 mid-FETCH with `imem_ready`=1 -> no `fetch_valid`, PC=RESET_ADDR, `imem_req`=0 the next cycle.
